// File: rtl/alu_shl_arbiter_pkg.sv
// rtl/alu_shl_arbiter_pkg.sv - shared types and widths for the shift-unit arbiter
// Purpose: FSM state encoding and datapath widths used by alu_shl_arbiter and SHL4bit.
package alu_shl_arbiter_pkg;

  localparam int DATA_W  = 4;  // operand / result width
  localparam int SHAMT_W = 2;  // effective shift-amount width
  localparam int ID_W    = 1;  // requester-ID width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shl_arbiter_shl4bit.sv
// rtl/alu_shl_arbiter_shl4bit.sv - combinational 4-bit left shifter
// Purpose: y = a << b, truncated to DATA_W bits.
// Ports:
//   a  in  DATA_W  operand
//   b  in  DATA_W  shift amount
//   y  out DATA_W  shifted result
module SHL4bit
  import alu_shl_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = a << b;

endmodule

// File: rtl/alu_shl_arbiter.sv
// rtl/alu_shl_arbiter.sv - round-robin arbiter sharing one 4-bit left shifter
// Purpose: accepts one operation at a time from two requesters, shifts it in a
// single EXEC cycle and holds the tagged result on the response channel.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req0_valid/ready/a/b              requester 0 handshake and operands
//   req1_valid/ready/a/b              requester 1 handshake and operands
//   rsp_valid/ready                   response handshake
//   rsp_id, rsp_r, rsp_ovf            issuing requester, result, overflow flag
module alu_shl_arbiter
  import alu_shl_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_ovf
);

  state_t               state, state_nxt;
  logic                 ptr;
  logic [DATA_W-1:0]    a_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [ID_W-1:0]      id_q;
  logic                 grant_any;
  logic                 grant_id;
  logic                 accept;
  logic [DATA_W-1:0]    shl_y;
  logic                 ovf;
  logic                 unused_b_hi;

  // Upper shift-amount bits are architecturally ignored.
  assign unused_b_hi = ^{req0_b[3:2], req1_b[3:2]};

  // Grant: a lone requester wins; on contention ptr decides.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ptr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated by rst so nothing is acknowledged in the reset cycle.
  assign accept = (state == IDLE) && grant_any && !rst;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req0_ready = !grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  SHL4bit u_shl (
    .a (a_q),
    .b ({2'b00, shamt_q}),
    .y (shl_y)
  );

  // Overflow = OR of the bits pushed past the top of the 4-bit result.
  always_comb begin
    case (shamt_q)
      2'd0:    ovf = 1'b0;
      2'd1:    ovf = a_q[3];
      2'd2:    ovf = |a_q[3:2];
      default: ovf = |a_q[3:1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= RR_INIT;
      a_q     <= '0;
      shamt_q <= '0;
      id_q    <= '0;
      rsp_r   <= '0;
      rsp_id  <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= grant_id ? req1_a : req0_a;
        shamt_q <= grant_id ? req1_b[1:0] : req0_b[1:0];
        id_q    <= grant_id;
        ptr     <= ~grant_id;  // the loser gets priority next time
      end
      if (state == EXEC) begin
        rsp_r   <= shl_y;
        rsp_ovf <= ovf;
        rsp_id  <= id_q;
      end
    end
  end

endmodule
